// File: rtl/masked_mem_arbiter.sv
// Two-requester round-robin front end for a 256x32 masked-write memory.
// Every client write becomes a read-modify-write so unmasked bits survive
// the memory's "store wr_data & mask" behaviour.
module masked_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_mask,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_c_en,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_mask,
    output logic [DATA_W-1:0]   mem_wr_data,
    input  logic [DATA_W-1:0]   mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [1:0]          grant;
    logic                sel;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        sel = grant[1];
    end

    // Next-state and capture logic for the IDLE -> RD -> DATA sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    state_d      = S_RD;
                    last_grant_d = sel;
                    id_d         = sel;
                    wr_d         = sel ? req_wr[1] : req_wr[0];
                    addr_d       = sel ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
                    mask_d       = sel ? req_mask[2*DATA_W-1:DATA_W]   : req_mask[DATA_W-1:0];
                    wdata_d      = sel ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
                end
            end
            S_RD:    state_d = S_DATA;
            S_DATA:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state; reset forces every output low,
    // which also drops a write and response that happen to be in DATA.
    always_comb begin
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        rsp_rdata   = '0;
        mem_c_en    = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_mask    = '0;
        mem_wr_data = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: req_ready = grant;
                S_RD: begin
                    mem_c_en = 1'b1;
                    mem_addr = addr_q;
                end
                S_DATA: begin
                    rsp_valid = id_q ? 2'b10 : 2'b01;
                    rsp_rdata = mem_rd_data;
                    if (wr_q) begin
                        mem_c_en    = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = addr_q;
                        mem_mask    = '1;
                        mem_wr_data = (mem_rd_data & ~mask_q) | (wdata_q & mask_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // State, round-robin pointer and captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule
